store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 16, memory address width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: store_addr  input  ADDR_W  base byte address of the store.
REQ-006 SHALL have port: store_data  input  32  value to store (ALU result).
REQ-007 SHALL have port: size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-008 SHALL have port: busy  output  1  high while in WRITE.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  one-cycle pulse, coincident with done, for reserved size.
REQ-011 SHALL have port: mem_address  output  ADDR_W  byte address driven to the byte memory.
REQ-012 SHALL have port: mem_write_data  output  8  byte driven to the byte memory.
REQ-013 SHALL have port: mem_write_enable  output  1  byte write strobe to the byte memory.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE and DONE; all outputs SHALL be registered.
REQ-015 SHALL, in IDLE with start=1, latch store_addr, store_data and size, then enter WRITE (size 00/01/10) or DONE (size 11) on the next edge.
REQ-016 SHALL define beat count N = 1, 2 or 4 for sizes 00, 01 and 10, and SHALL hold a beat counter i from 0 to N-1.
REQ-017 SHALL, in WRITE, drive for each beat i: mem_write_enable=1, mem_address=(base+i) mod 2^ADDR_W, and mem_write_data=store_data[8i+7:8i] (little-endian).
REQ-018 SHALL go from WRITE to DONE after beat N-1; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 SHALL set err=1 in DONE only for size 11; no write beat SHALL occur for size 11.
REQ-020 SHALL have latency: start sampled at edge t, beats in cycles t+1..t+N, done in cycle t+N+1, next start accepted at edge t+N+2.
REQ-021 SHALL ignore start while in WRITE or DONE; the latched request SHALL NOT be altered.
REQ-022 SHALL drive mem_write_enable=0 and mem_write_data=8'h00 outside WRITE, and SHALL hold mem_address at its last value.
REQ-023 SHALL wrap the address past 2^ADDR_W-1 to 0 with no error indication.
REQ-024 SHALL ignore store_data, store_addr and size changes after the start edge.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter IDLE and set busy=0, done=0, err=0, mem_write_enable=0, mem_write_data=8'h00, mem_address=0 and the beat counter to 0.
REQ-026 SHALL give rst priority over start when both are sampled high at the same edge.
REQ-027 SHALL, on rst during WRITE, abandon the remaining beats: mem_write_enable=0 from the cycle after the reset edge, and no done pulse.

Verification
REQ-028 SHALL pass: word store, store_data=32'h00008000, addr=16'h0000 -> bytes 00,80,00,00 written to 0000..0003 in 4 consecutive cycles, done in the 5th cycle, err=0.
REQ-029 SHALL pass: byte store, store_data=32'h123456FF, addr=16'h0010 -> one beat writing FF to 0010, done in the next cycle.
REQ-030 SHALL pass: halfword store, store_data=32'h0000ABCD, addr=16'hFFFF -> CD written to FFFF, then AB written to 0000.
REQ-031 SHALL pass: word store with rst asserted in beat 2 -> only 2 bytes written, no done pulse, all outputs at reset values; a subsequent start is accepted normally.
REQ-032 SHALL pass: start pulsed again during WRITE with different data/addr -> ignored, and the original 4 bytes are written unchanged.
REQ-033 SHALL pass: size=11 -> no mem_write_enable pulse, done=1 and err=1 together in the cycle after start.

Source files
------------

// File: rtl/store_unit.sv
// Byte-serial store unit: splits a byte/halfword/word store into little-endian
// byte beats on a byte-wide memory port, then pulses done (with err for size 11).
module store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [31:0]       store_data,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_write_data,
    output logic              mem_write_enable,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_beat;

    logic              busy_d, done_d, err_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;

    assign state_dbg = state_q;

    always_comb begin
        case (size_q)
            2'b00:   last_beat = 2'd0;
            2'b01:   last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    end

    // Next-state logic; the request is latched only on an accepted start in IDLE.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        data_d  = data_q;
        size_d  = size_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                beat_d = 2'd0;
                if (start) begin
                    base_d  = store_addr;
                    data_d  = store_data;
                    size_d  = size;
                    state_d = (size == 2'b11) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (beat_q == last_beat) begin
                    beat_d  = 2'd0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered values line up
    // with the state they describe in the same cycle.
    always_comb begin
        busy_d  = (state_d == WRITE);
        we_d    = (state_d == WRITE);
        done_d  = (state_d == DONE);
        err_d   = (state_q == IDLE) && (state_d == DONE);
        addr_d  = mem_address;
        wdata_d = 8'h00;
        if (state_d == WRITE) begin
            addr_d = base_d + {{(ADDR_W-2){1'b0}}, beat_d};
            case (beat_d)
                2'd0:    wdata_d = data_d[7:0];
                2'd1:    wdata_d = data_d[15:8];
                2'd2:    wdata_d = data_d[23:16];
                default: wdata_d = data_d[31:24];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            base_q           <= '0;
            data_q           <= '0;
            size_q           <= '0;
            beat_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_write_data   <= 8'h00;
            mem_address      <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            data_q           <= data_d;
            size_q           <= size_d;
            beat_q           <= beat_d;
            busy             <= busy_d;
            done             <= done_d;
            err              <= err_d;
            mem_write_enable <= we_d;
            mem_write_data   <= wdata_d;
            mem_address      <= addr_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: drivers push timestamped expected beats and done pulses
// into exp_q; a negedge monitor pops and compares whatever the DUT presents.
module tb_store_unit;

    localparam int ADDR_W = 16;
    localparam int W      = 58;  // {cycle[31:0], is_done, err, addr[15:0], data[7:0]}

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] store_addr;
    logic [31:0]       store_data;
    logic [1:0]        size;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_write_data;
    logic              mem_write_enable;
    logic [1:0]        state_dbg;

    logic [W-1:0]      exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int unsigned       cyc = 0;
    logic [15:0]       model_last_addr = 16'h0000;
    bit                mon_en = 1'b0;

    store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .store_addr       (store_addr),
        .store_data       (store_data),
        .size             (size),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .state_dbg        (state_dbg)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] mk(input int unsigned c, input bit is_done, input bit e,
                                        input logic [15:0] a, input logic [7:0] d);
        return {c[31:0], is_done, e, a, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        if (mon_en) begin
            if (mem_write_enable) begin
                got = mk(cyc, 1'b0, 1'b0, mem_address, mem_write_data);
                if (exp_q.size() == 0) unexpected("write_beat", 64'(got));
                else begin
                    e = exp_q.pop_front();
                    check("write_beat", 64'(got), 64'(e));
                    model_last_addr = e[23:8];
                end
            end else begin
                check("idle_data", 64'(mem_write_data), 64'h0);
                check("addr_hold", 64'(mem_address), 64'(model_last_addr));
            end
            if (busy || mem_write_enable) check("busy_vs_write", 64'(busy), 64'(mem_write_enable));
            if (done) begin
                got = mk(cyc, 1'b1, err, 16'h0, 8'h0);
                if (exp_q.size() == 0) unexpected("done_pulse", 64'(got));
                else begin
                    e = exp_q.pop_front();
                    check("done_pulse", 64'(got), 64'(e));
                end
            end else if (err) begin
                unexpected("err_without_done", 64'(err));
            end
        end
    end

    task automatic scramble_inputs();
        store_addr = 16'($urandom);
        store_data = $urandom;
        size       = 2'($urandom_range(0, 3));
    endtask

    // Called one step after a rising edge with the DUT able to accept a start.
    // junk: 0 = start low after the start edge, 1 = start held high, 2 = random start.
    task automatic do_store(input logic [15:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int junk);
        int          n;
        int unsigned t;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        start      = 1'b1;
        store_addr = a;
        store_data = d;
        size       = sz;
        t          = cyc + 1;
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(t + i, 1'b0, 1'b0, 16'((32'(a) + i) % 65536), 8'((d >> (8 * i)) & 32'hFF)));
        exp_q.push_back(mk(t + n, 1'b1, (sz == 2'b11), 16'h0, 8'h0));
        for (int k = 0; k <= n; k++) begin
            @(posedge clk);
            #1;
            start = (junk == 1) ? 1'b1 : (junk == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            scramble_inputs();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_err"}, 64'(err), 64'h0);
        check({tag, "_we"}, 64'(mem_write_enable), 64'h0);
        check({tag, "_wdata"}, 64'(mem_write_data), 64'h0);
        check({tag, "_addr"}, 64'(mem_address), 64'h0);
        check({tag, "_state"}, 64'(state_dbg), 64'h0);
    endtask

    // One reset edge, optionally with start asserted at the same edge.
    task automatic apply_reset(input bit with_start);
        rst   = 1'b1;
        start = with_start;
        scramble_inputs();
        @(posedge clk);
        #1;
        model_last_addr = 16'h0000;
        rst   = 1'b0;
        start = 1'b0;
        check_reset_values("reset");
    endtask

    // Word store with reset asserted during the second beat.
    task automatic store_with_reset(input logic [15:0] a, input logic [31:0] d);
        int unsigned t;
        start      = 1'b1;
        store_addr = a;
        store_data = d;
        size       = 2'b10;
        t          = cyc + 1;
        for (int i = 0; i < 2; i++)
            exp_q.push_back(mk(t + i, 1'b0, 1'b0, 16'((32'(a) + i) % 65536), 8'((d >> (8 * i)) & 32'hFF)));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_last_addr = 16'h0000;
        rst = 1'b0;
        check_reset_values("mid_reset");
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        store_addr = '0;
        store_data = '0;
        size       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");
        mon_en = 1'b1;

        do_store(16'h0000, 32'h00008000, 2'b10, 0);
        do_store(16'h0010, 32'h123456FF, 2'b00, 0);
        do_store(16'hFFFF, 32'h0000ABCD, 2'b01, 0);
        store_with_reset(16'h0200, 32'hA1B2C3D4);
        do_store(16'h0300, 32'h11223344, 2'b10, 0);
        do_store(16'h1234, 32'hDEADBEEF, 2'b10, 1);
        do_store(16'h5555, 32'h89ABCDEF, 2'b11, 0);
        do_store(16'hFFFE, 32'hCAFEF00D, 2'b10, 0);
        apply_reset(1'b1);
        repeat (4) @(posedge clk);
        #1;

        for (int r = 0; r < 200; r++) begin
            do_store(16'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 49) == 0) apply_reset($urandom_range(0, 1) == 1);
        end

        repeat (8) @(posedge clk);
        #1;
        check("queue_drain", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
